// File: rtl/fnn_pkg.sv
// Shared defaults and types for the weight streaming memory.
// addr_w() keeps index ports at least one bit wide for single-weight neurons.
package fnn_pkg;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int NUM_WEIGHT_DEF = 30;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/weight_ram.sv
// 1W1R synchronous weight RAM; the read register doubles as the stream data register.
// Only the output register is reset, the array is not.
module weight_ram #(
   parameter int DEPTH = 30,
   parameter int DW    = 16,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/weight_stream_mem.sv
// Weight store for one neuron: loads weights while idle, then streams all of them
// in address order to the MAC with a valid/ready handshake.
module weight_stream_mem
   import fnn_pkg::*;
#(
   parameter int NUM_WEIGHT = NUM_WEIGHT_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = addr_w(NUM_WEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  clear,
   input  logic                  start,
   output logic                  busy,
   output logic                  loaded,
   output logic                  start_err,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic [ADDR_WIDTH-1:0] w_index,
   output logic                  w_last
);
   localparam logic [ADDR_WIDTH:0] NW_P   = (ADDR_WIDTH+1)'(NUM_WEIGHT);
   localparam logic [ADDR_WIDTH:0] LAST_P = NW_P - 1'b1;

   state_e                  state_q;
   logic [NUM_WEIGHT-1:0]   valid_q, valid_d;
   logic [ADDR_WIDTH:0]     rd_ptr_q;
   logic [ADDR_WIDTH-1:0]   w_index_q;
   logic                    loaded_q, start_err_q, w_valid_q, w_last_q;
   logic                    wr_fire, rd_issue, last_acc;

   assign wr_ready = (state_q == IDLE);
   assign busy     = (state_q == STREAM);
   // Out-of-range writes handshake normally but touch neither RAM nor valid bits.
   assign wr_fire  = wr_valid && wr_ready && ({1'b0, wr_addr} < NW_P);
   assign rd_issue = busy && (rd_ptr_q < NW_P) && (!w_valid_q || w_ready);
   assign last_acc = w_valid_q && w_ready && w_last_q;

   always_comb begin
      valid_d = valid_q;
      if (wr_ready && clear) valid_d = '0;
      else if (wr_fire)      valid_d[wr_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         valid_q     <= '0;
         loaded_q    <= 1'b0;
         start_err_q <= 1'b0;
         w_valid_q   <= 1'b0;
         w_index_q   <= '0;
         w_last_q    <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         loaded_q    <= &valid_d;
         start_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (loaded_q) begin
                     state_q  <= STREAM;
                     rd_ptr_q <= '0;
                  end else begin
                     start_err_q <= 1'b1;
                  end
               end
            end
            STREAM: begin
               // rd_ptr runs one past the last address, so no issue follows the final read.
               if (rd_issue) begin
                  rd_ptr_q  <= rd_ptr_q + 1'b1;
                  w_valid_q <= 1'b1;
                  w_index_q <= rd_ptr_q[ADDR_WIDTH-1:0];
                  w_last_q  <= (rd_ptr_q == LAST_P);
               end else if (w_ready) begin
                  w_valid_q <= 1'b0;
               end
               if (last_acc) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   weight_ram #(
      .DEPTH (NUM_WEIGHT),
      .DW    (DATA_WIDTH),
      .AW    (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_fire),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_issue),
      .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata (w_data)
   );

   assign loaded    = loaded_q;
   assign start_err = start_err_q;
   assign w_valid   = w_valid_q;
   assign w_index   = w_index_q;
   assign w_last    = w_last_q;
endmodule

// File: tb/tb_weight_stream_mem.sv
// Bench for weight_stream_mem: a table of idle-state events, directed pass scenarios
// and randomized passes, all checked against a queue/array reference model.
module tb_weight_stream_mem;
   localparam int NW = 30, DW = 16, AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr_valid = 0, clear = 0, start = 0, w_ready = 0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic wr_ready, busy, loaded, start_err, w_valid, w_last;
   logic [DW-1:0] w_data;
   logic [AW-1:0] w_index;

   logic wr_valid1 = 0, clear1 = 0, start1 = 0, w_ready1 = 0;
   logic [0:0] wr_addr1 = '0;
   logic [DW-1:0] wr_data1 = '0;
   logic wr_ready1, busy1, loaded1, start_err1, w_valid1, w_last1;
   logic [DW-1:0] w_data1;
   logic [0:0] w_index1;

   always #5 clk = ~clk;

   weight_stream_mem #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .clear(clear), .start(start), .busy(busy), .loaded(loaded),
      .start_err(start_err), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_index(w_index), .w_last(w_last));

   weight_stream_mem #(.NUM_WEIGHT(1), .DATA_WIDTH(DW)) dut1 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_addr(wr_addr1),
      .wr_data(wr_data1), .clear(clear1), .start(start1), .busy(busy1), .loaded(loaded1),
      .start_err(start_err1), .w_valid(w_valid1), .w_ready(w_ready1), .w_data(w_data1),
      .w_index(w_index1), .w_last(w_last1));

   int vecs = 0, errs = 0;

   // reference model
   logic [DW-1:0] ref_mem [NW];
   bit ref_vld [NW];
   bit m_busy = 0, m_loaded = 0, m_err = 0;
   typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; logic last; } beat_t;
   beat_t got_q[$];
   bit saw_first = 0;
   int gaps = 0;

   typedef struct { int op; int addr; int data; bit exp_loaded; bit exp_err; } tv_t;
   tv_t tv[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit all_vld();
      foreach (ref_vld[i]) if (!ref_vld[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      foreach (ref_vld[i]) ref_vld[i] = 1'b0;
      m_busy = 0; m_loaded = 0; m_err = 0;
   endtask

   // One clock: predict the effect of the current inputs, take the edge, compare.
   task automatic cyc();
      bit nb, hold;
      logic [DW-1:0] pd; logic [AW-1:0] pi; logic pl;
      m_err = 0;
      nb = m_busy;
      if (!m_busy) begin
         if (clear) foreach (ref_vld[i]) ref_vld[i] = 1'b0;
         else if (wr_valid && wr_addr < NW) begin
            ref_mem[wr_addr] = wr_data;
            ref_vld[wr_addr] = 1'b1;
         end
         if (start) begin
            if (m_loaded) begin nb = 1; got_q.delete(); saw_first = 0; gaps = 0; end
            else m_err = 1;
         end
      end else begin
         if (w_valid && w_ready) begin
            got_q.push_back('{w_index, w_data, w_last});
            saw_first = 1;
            if (got_q.size() == NW) nb = 0;
         end else if (!w_valid && saw_first) gaps++;
      end
      hold = (w_valid === 1'b1) && !w_ready;
      pd = w_data; pi = w_index; pl = w_last;
      m_busy = nb;
      m_loaded = all_vld();
      @(posedge clk); #1;
      chk("loaded", loaded, m_loaded);
      chk("wr_ready", wr_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("start_err", start_err, m_err);
      if (!m_busy) chk("w_valid_idle", w_valid, 0);
      if (hold) begin
         chk("hold_valid", w_valid, 1);
         chk("hold_data", w_data, pd);
         chk("hold_index", w_index, pi);
         chk("hold_last", w_last, pl);
      end
   endtask

   task automatic chk_rst_outs();
      chk("rst_w_valid", w_valid, 0);   chk("rst_w_last", w_last, 0);
      chk("rst_w_index", w_index, 0);   chk("rst_w_data", w_data, 0);
      chk("rst_busy", busy, 0);         chk("rst_loaded", loaded, 0);
      chk("rst_start_err", start_err, 0); chk("rst_wr_ready", wr_ready, 1);
   endtask

   task automatic do_reset();
      rst = 1; model_reset(); #1;
      chk_rst_outs();
      @(posedge clk); #1; rst = 0;
   endtask

   task automatic load_all(input bit inc);
      for (int a = 0; a < NW; a++) begin
         wr_valid = 1; wr_addr = AW'(a);
         wr_data = inc ? DW'(16'h100 + a) : DW'($urandom);
         cyc();
      end
      wr_valid = 0;
   endtask

   task automatic check_pass();
      chk("beat_count", got_q.size(), NW);
      for (int i = 0; i < got_q.size() && i < NW; i++) begin
         chk($sformatf("beat%0d_index", i), got_q[i].idx, i);
         chk($sformatf("beat%0d_data", i), got_q[i].data, ref_mem[i]);
         chk($sformatf("beat%0d_last", i), got_q[i].last, (i == NW-1));
      end
      chk("bubbles", gaps, 0);
   endtask

   // mode 0: ready always 1; 1: 3-cycle stall at index 7; 2: random ready
   task automatic pass(input int mode, input bit poke);
      int n = 0, stall = 0;
      start = 1; w_ready = 1; cyc(); start = 0;
      while (m_busy && n < 400) begin
         case (mode)
            0: w_ready = 1;
            1: begin
               w_ready = !(w_valid && w_index == 7 && stall < 3);
               if (!w_ready) stall++;
            end
            default: w_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke) begin
            wr_valid = 1'($urandom); wr_addr = AW'($urandom_range(0, NW-1));
            wr_data = DW'($urandom); clear = 1'($urandom); start = 1'($urandom);
         end
         cyc(); n++;
      end
      wr_valid = 0; clear = 0; start = 0; w_ready = 1;
      if (m_busy) begin chk("pass_timeout", 1, 0); m_busy = 0; end
      if (mode == 0) chk("pass_cycles", n, NW + 1);
      if (mode == 1) begin chk("pass_cycles", n, NW + 4); chk("stall_cycles", stall, 3); end
      check_pass();
   endtask

   initial begin
      tv[0] = '{3, 0, 0, 0, 1};          // start while not loaded
      tv[1] = '{0, 0, 0, 0, 0};
      tv[2] = '{1, 31, 16'hDEAD, 0, 0};  // out of range write
      tv[3] = '{1, 29, 16'h011D, 1, 0};  // last missing address
      tv[4] = '{1, 31, 16'hBEEF, 1, 0};
      tv[5] = '{2, 0, 0, 0, 0};          // clear
      tv[6] = '{3, 0, 0, 0, 1};
      tv[7] = '{1, 3, 16'h0103, 0, 0};

      do_reset();
      for (int a = 0; a < NW-1; a++) begin
         wr_valid = 1; wr_addr = AW'(a); wr_data = DW'(16'h100 + a); cyc();
      end
      wr_valid = 0;
      foreach (tv[i]) begin
         wr_valid = (tv[i].op == 1); clear = (tv[i].op == 2); start = (tv[i].op == 3);
         wr_addr = AW'(tv[i].addr); wr_data = DW'(tv[i].data);
         cyc();
         chk($sformatf("tv%0d_loaded", i), loaded, tv[i].exp_loaded);
         chk($sformatf("tv%0d_start_err", i), start_err, tv[i].exp_err);
         wr_valid = 0; clear = 0; start = 0;
      end

      load_all(1);
      pass(0, 0);
      pass(1, 0);
      pass(0, 1);
      clear = 1; cyc(); clear = 0;
      chk("clear_after_pass", loaded, 0);
      load_all(1);
      chk("reload", loaded, 1);

      // clear beats a same-cycle write
      clear = 1; wr_valid = 1; wr_addr = 0; wr_data = 16'h7777; cyc(); clear = 0;
      for (int a = 1; a < NW; a++) begin wr_addr = AW'(a); wr_data = DW'(16'h200 + a); cyc(); end
      chk("clear_priority", loaded, 0);
      wr_addr = 0; wr_data = 16'h0200; cyc(); wr_valid = 0;
      chk("priority_reload", loaded, 1);

      for (int r = 0; r < 3; r++) begin
         load_all(0);
         for (int k = 0; k < 40; k++) begin
            wr_valid = 1'($urandom); wr_addr = AW'($urandom_range(0, 31)); wr_data = DW'($urandom);
            cyc();
         end
         wr_valid = 0;
         pass(2, 1);
      end

      // reset in the middle of a pass
      load_all(1);
      start = 1; w_ready = 1; cyc(); start = 0;
      for (int n = 0; n < 100 && got_q.size() < 12; n++) cyc();
      chk("pre_reset_beats", got_q.size(), 12);
      rst = 1; model_reset(); #1;
      chk("midrst_w_valid", w_valid, 0);
      chk("midrst_loaded", loaded, 0);
      chk("midrst_busy", busy, 0);
      #3 rst = 0;
      repeat (3) cyc();
      chk("no_beats_after_rst", got_q.size(), 12);
      start = 1; cyc(); start = 0;
      chk("start_after_rst", start_err, 1);

      // single-weight instance
      chk("n1_loaded0", loaded1, 0);
      wr_valid1 = 1; wr_addr1 = 0; wr_data1 = 16'h5A5A;
      @(posedge clk); #1; wr_valid1 = 0;
      chk("n1_loaded", loaded1, 1);
      start1 = 1; @(posedge clk); #1; start1 = 0;
      chk("n1_busy", busy1, 1);
      w_ready1 = 1; @(posedge clk); #1;
      chk("n1_w_valid", w_valid1, 1);
      chk("n1_w_data", w_data1, 16'h5A5A);
      chk("n1_w_index", w_index1, 0);
      chk("n1_w_last", w_last1, 1);
      @(posedge clk); #1;
      chk("n1_done_busy", busy1, 0);
      chk("n1_done_valid", w_valid1, 0);
      chk("n1_done_wr_ready", wr_ready1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/weight_stream_mem.md
WEIGHT_STREAM_MEM -- requirements
Module: weight_stream_mem

Interface
REQ-001 The block SHALL have parameter NUM_WEIGHT, default 30, meaning the number of weights per neuron and the RAM depth.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the width of one signed fixed-point weight.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(NUM_WEIGHT), meaning the address and index width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed in REQ-005 to REQ-017.
REQ-005 clk  input  1  the single clock; all logic is rising-edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_valid  input  1  a weight write is offered.
REQ-008 wr_ready  output  1  a write can be accepted; high only in IDLE.
REQ-009 wr_addr  input  ADDR_WIDTH  the write address.
REQ-010 wr_data  input  DATA_WIDTH  the write data.
REQ-011 clear  input  1  single-cycle pulse that invalidates all loaded weights.
REQ-012 start  input  1  single-cycle pulse that requests one streaming pass.
REQ-013 busy  output  1  high while the state is STREAM.
REQ-014 loaded  output  1  high when every address has been written since the last reset or clear.
REQ-015 start_err  output  1  single-cycle pulse when a start is rejected.
REQ-016 w_valid, w_ready  output, input  1, 1  the stream handshake to the MAC.
REQ-017 w_data, w_index, w_last  output  DATA_WIDTH, ADDR_WIDTH, 1  the weight, its address, and an end-of-pass marker.

Function
REQ-018 A write SHALL be performed in a cycle where wr_valid && wr_ready is true; it sets valid bit wr_addr, and its data is readable from the next cycle.
REQ-019 A write with wr_addr >= NUM_WEIGHT SHALL be accepted and discarded, leaving the RAM and the valid bits unchanged.
REQ-020 loaded SHALL equal the AND of the NUM_WEIGHT valid bits, registered, so it rises the cycle after the last missing write.
REQ-021 In IDLE, clear SHALL zero all valid bits, leave the RAM contents untouched, and take priority over a write in the same cycle.
REQ-022 clear SHALL be ignored in STREAM.
REQ-023 The FSM SHALL have two states: IDLE and STREAM.
REQ-024 In IDLE, start with loaded=1 SHALL move the FSM to STREAM and set rd_ptr=0.
REQ-025 In IDLE, start with loaded=0 SHALL leave the FSM in IDLE and pulse start_err for one cycle.
REQ-026 start in STREAM SHALL be ignored with no start_err pulse.
REQ-027 In STREAM, a read of rd_ptr SHALL issue when rd_ptr < NUM_WEIGHT and (!w_valid || w_ready), after which rd_ptr increments.
REQ-028 The RAM output register SHALL be the w_data register, with 1-cycle read latency; w_valid rises the cycle after an issue.
REQ-029 The stream SHALL sustain one weight per cycle with no bubbles while w_ready=1.
REQ-030 When w_valid=1 and w_ready=0, w_data, w_index and w_last SHALL be held stable and no read SHALL issue.
REQ-031 w_index SHALL equal the address of w_data, and w_last SHALL be 1 only when w_index = NUM_WEIGHT-1.
REQ-032 The FSM SHALL return to IDLE in the cycle after the beat with w_last accepted; w_valid=0 and wr_ready=1 from that cycle.
REQ-033 Arithmetic SHALL be limited to address compare and increment: rd_ptr is ADDR_WIDTH+1 bits so it does not wrap, and data is never modified.
REQ-034 The block SHALL pass the NUM_WEIGHT=1 boundary case: a single beat with w_last=1.

Reset
REQ-035 Reset SHALL put the FSM in IDLE, set rd_ptr=0 and clear all valid bits.
REQ-036 Reset SHALL set the outputs to: w_valid=0, w_last=0, w_index=0, w_data=0, busy=0, loaded=0, start_err=0, wr_ready=1.
REQ-037 The RAM array SHALL NOT be reset.
REQ-038 Reset asserted mid-STREAM SHALL abort the pass immediately, with no further beats, and require a full reload before the next pass.

Structure
REQ-039 Package fnn_pkg SHALL hold DATA_WIDTH_DEF=16, NUM_WEIGHT_DEF=30 and the state enum typedef (IDLE, STREAM).
REQ-040 The design SHALL use one sub-module, weight_ram: 1W1R synchronous RAM with read enable and a registered output, and no reset on its array.

Verification
REQ-041 Load addresses 0..29 with data=addr+0x100; loaded rises the cycle after addr 29; start with w_ready=1 -> 30 consecutive beats, w_data 0x100..0x11D, w_last only on index 29, busy falls after.
REQ-042 Write 0..28 only, then start -> start_err pulses once, busy stays 0, and no w_valid.
REQ-043 During streaming, drop w_ready for 3 cycles at index 7 -> index 7 is held with stable data, and index 8 follows with no loss or duplication.
REQ-044 Offer writes and clear while busy -> wr_ready=0, nothing is written, and loaded stays 1; after the pass, clear -> loaded=0 next cycle, and a rewrite of 0..29 restores loaded=1.
REQ-045 Assert rst at beat 12 -> w_valid=0 and loaded=0 immediately; a subsequent start gives start_err.
REQ-046 Write to addr 31 -> accepted and no effect; loaded and the RAM are unchanged.
